spi_controller: RTL and testbench

//  SPI initiator that issues one register access per request to an spi_peripheral/reg_bank target.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_clk_div.sv | 29 ++
 rtl/spi_controller.sv | 127 ++++++++++++
 tb/tb_spi_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and field positions for the SPI register-access initiator.
// Pure declarations: no timing, no flow control.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_t;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  // Write/read flag sits in the MSB of the command byte.
  function automatic int wr_bit_pos(input int reg_w);
    return reg_w - 1;
  endfunction

  function automatic int frame_msb(input int reg_w);
    return 2 * reg_w - 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Free-running divider: tick high on every CLK_DIV-th clk cycle, restarted by clr.
// Latency: first tick CLK_DIV cycles after clr; no backpressure.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstb,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstb || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/spi_controller.sv
// SPI initiator issuing one {cmd,data} register frame per accepted start.
// Latency 1+CLK_DIV*(4*REG_W+2) cycles start->done; start is dropped (not queued) while busy.
module spi_controller
  import spi_pkg::*;
#(
  parameter int REG_W   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             wr_rdn,
  input  logic [REG_W-2:0] addr,
  input  logic [REG_W-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [REG_W-1:0] rdata,
  output logic             spi_cs_n,
  output logic             spi_clk,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int FW        = 2 * REG_W;
  localparam int FRAME_MSB = frame_msb(REG_W);
  localparam int WR_BIT    = wr_bit_pos(REG_W);
  localparam int HW        = $clog2(4 * REG_W);
  localparam logic [HW-1:0] HP_LAST = HW'(4 * REG_W - 1);

  spi_state_t state, state_nxt;

  logic             tick;
  logic             accept;
  logic             leading;
  logic             sample_now;
  logic             shift_now;
  logic [REG_W-1:0] cmd;
  logic [FW-1:0]    tx;
  logic [REG_W-1:0] rx;
  logic [HW-1:0]    hidx;
  logic             clk_q;
  logic             done_q;
  logic             is_wr;
  logic             cpha;

  assign cmd    = {wr_rdn, addr};
  assign accept = (state == IDLE) && start && ena;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk  (clk),
    .rstb (rstb),
    .clr  (accept),
    .tick (tick)
  );

  // Even half-periods end on a leading edge; CPHA selects which edge samples.
  assign leading    = ~hidx[0];
  assign sample_now = cpha ? ~leading : leading;
  assign shift_now  = (cpha ? leading : ~leading) && (hidx != '0) && (hidx != HP_LAST);

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   if (tick) state_nxt = SHIFT;
      SHIFT:   if (tick && (hidx == HP_LAST)) state_nxt = HOLD;
      HOLD:    if (tick) state_nxt = GAP;
      GAP:     if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      tx     <= '0;
      rx     <= '0;
      rdata  <= '0;
      hidx   <= '0;
      clk_q  <= 1'b0;
      done_q <= 1'b0;
      is_wr  <= 1'b0;
      cpha   <= 1'b0;
    end else begin
      done_q <= (state == HOLD) && tick;
      case (state)
        IDLE: begin
          clk_q <= mode[CPOL_BIT];
          hidx  <= '0;
          if (accept) begin
            tx    <= {cmd, wdata};
            is_wr <= cmd[WR_BIT];
            cpha  <= mode[CPHA_BIT];
          end
        end
        SHIFT: begin
          if (tick) begin
            clk_q <= ~clk_q;
            hidx  <= hidx + 1'b1;
            if (sample_now) rx <= {rx[REG_W-2:0], spi_miso};
            if (shift_now) tx <= {tx[FW-2:0], 1'b0};
          end
        end
        HOLD: begin
          if (tick && !is_wr) rdata <= rx;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign spi_cs_n = !((state == SETUP) || (state == SHIFT) || (state == HOLD));
  assign spi_clk  = clk_q;
  assign spi_mosi = spi_cs_n ? 1'b0 : tx[FRAME_MSB];
  assign done     = done_q;

endmodule

// File: tb/tb_spi_controller.sv
// Randomized bench: behavioural SPI register target plus a memory/latency reference model.
module tb_spi_controller;

  localparam int W   = 8;
  localparam int DIV = 4;
  localparam int LAT_DONE  = 1 + DIV * (4 * W + 2);
  localparam int LAT_BUSY  = LAT_DONE + DIV;
  localparam int LAT1_DONE = 1 + 1 * (4 * W + 2);

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         ena = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         start = 1'b0;
  logic         wr_rdn = 1'b0;
  logic [W-2:0] addr = '0;
  logic [W-1:0] wdata = '0;
  logic         busy, done, cs_n, spi_clk, spi_mosi;
  logic [W-1:0] rdata;
  logic         spi_miso = 1'b0;

  logic         start1 = 1'b0;
  logic         busy1, done1, cs1_n, spi_clk1, spi_mosi1;
  logic [W-1:0] rdata1;

  spi_controller #(.REG_W(W), .CLK_DIV(DIV)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .mode(mode), .start(start), .wr_rdn(wr_rdn),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .spi_cs_n(cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_controller #(.REG_W(W), .CLK_DIV(1)) dut1 (
    .clk(clk), .rstb(rstb), .ena(1'b1), .mode(2'b00), .start(start1), .wr_rdn(1'b1),
    .addr(7'h03), .wdata(8'h55), .busy(busy1), .done(done1), .rdata(rdata1),
    .spi_cs_n(cs1_n), .spi_clk(spi_clk1), .spi_mosi(spi_mosi1), .spi_miso(1'b0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural register target: captures mosi, serves reads from per_mem.
  logic [7:0]  per_mem [128];
  logic [7:0]  exp_mem [128];
  logic [7:0]  exp_rdata = 8'h00;
  bit          cur_cpha = 1'b0;
  logic        prev_clk = 1'b0;
  logic        prev_cs = 1'b1;
  int          edge_n = 0, ncap = 0, tog = 0, rises = 0, cs_falls = 0, done_cnt = 0, last_ncap = 0;
  logic [15:0] cap = '0, last_cap = '0;
  logic [6:0]  p_addr = '0;

  task automatic drive_miso(input int k);
    if (k < 8) spi_miso = 1'($urandom_range(0, 1));
    else if (k < 16) spi_miso = per_mem[p_addr][15-k];
  endtask

  task automatic capture();
    cap = {cap[14:0], spi_mosi};
    ncap++;
    if (ncap == 8) p_addr = cap[6:0];
  endtask

  always @(negedge clk) begin
    if (!cs_n && prev_cs) begin
      cs_falls++;
      edge_n = 0;
      ncap = 0;
      cap = '0;
      if (!cur_cpha) drive_miso(0);
    end else if (!cs_n && (spi_clk !== prev_clk)) begin
      edge_n++;
      tog++;
      if (spi_clk) rises++;
      if ((edge_n % 2) == 1) begin
        if (cur_cpha) drive_miso(ncap);
        else capture();
      end else begin
        if (cur_cpha) capture();
        else drive_miso(ncap);
      end
    end else if (cs_n && !prev_cs) begin
      last_cap = cap;
      last_ncap = ncap;
      if (ncap == 16 && cap[15]) per_mem[cap[14:8]] = cap[7:0];
    end
    if (done) done_cnt++;
    prev_clk = spi_clk;
    prev_cs = cs_n;
  end

  task automatic run_frame(input bit wr, input logic [6:0] a, input logic [7:0] d,
                           input logic [1:0] m, input bit disturb);
    int s, off, t_cs, t_done, t_busy, d0, cf0;
    t_cs = -1; t_done = -1; t_busy = -1;
    @(negedge clk);
    wr_rdn = wr; addr = a; wdata = d; mode = m; ena = 1'b1; start = 1'b1;
    cur_cpha = m[0]; tog = 0; rises = 0; d0 = done_cnt; cf0 = cs_falls; s = cyc;
    if (wr) exp_mem[a] = d;
    else exp_rdata = exp_mem[a];
    for (int k = 1; k < 3000 && t_busy < 0; k++) begin
      @(negedge clk);
      off = cyc - s;
      start = disturb && (off == 5 || off == 100);
      if (off == 1) begin
        wr_rdn = 1'($urandom_range(0, 1));
        addr = 7'($urandom);
        wdata = 8'($urandom);
        mode = 2'($urandom);
      end
      if (disturb && off == 120) ena = 1'b0;
      if (!cs_n && t_cs < 0) t_cs = off;
      if (done && t_done < 0) t_done = off;
      if (!busy && t_busy < 0) t_busy = off;
    end
    check("frame_timeout", 32'(t_busy < 0), 32'd0);
    check("cs_fall_lat", 32'(t_cs), 32'd1);
    check("done_lat", 32'(t_done), 32'(LAT_DONE));
    check("busy_fall_lat", 32'(t_busy), 32'(LAT_BUSY));
    check("clk_toggles", 32'(tog), 32'd32);
    check("clk_rises", 32'(rises), 32'd16);
    check("mosi_bits", 32'(last_ncap), 32'd16);
    if (wr) check("mosi_frame", 32'(last_cap), 32'({wr, a, d}));
    else check("mosi_cmd", 32'(last_cap[15:8]), 32'({1'b0, a}));
    check("rdata", 32'(rdata), 32'(exp_rdata));
    ena = 1'b1;
    mode = m;
    repeat (2) @(negedge clk);
    check("idle_clk", 32'(spi_clk), 32'(m[1]));
    if (disturb) repeat (20) @(negedge clk);
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("frame_count", 32'(cs_falls - cf0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, off, t_cs, t_done, t_busy, d0, cf0;
    logic [7:0] v;
    for (int i = 0; i < 128; i++) begin
      v = 8'($urandom);
      per_mem[i] = v;
      exp_mem[i] = v;
    end

    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_spi_clk", 32'(spi_clk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_cs1_n", 32'(cs1_n), 32'd1);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0 write: leading-edge mosi must read 0x83 then 0xA5.
    run_frame(1'b1, 7'h03, 8'hA5, 2'd0, 1'b0);
    check("t1_frame", 32'(last_cap), 32'h83A5);
    check("t1_rdata_held", 32'(rdata), 32'h00);

    for (int m = 0; m < 4; m++) begin
      run_frame(1'b1, 7'h02, 8'h5A, 2'(m), 1'b0);
      run_frame(1'b0, 7'h02, 8'h00, 2'(m), 1'b0);
      check("loop_rdata", 32'(rdata), 32'h5A);
      check("loop_cmd", 32'(last_cap[15:8]), 32'h02);
    end

    for (int n = 0; n < 12; n++) begin
      run_frame(1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom),
                2'($urandom), 1'b0);
    end

    // Extra starts mid-frame and ena dropping must not disturb the frame.
    run_frame(1'b1, 7'h11, 8'h3C, 2'd1, 1'b1);

    @(negedge clk);
    ena = 1'b0; start = 1'b1; cf0 = cs_falls;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("ena0_no_frame", 32'(cs_falls - cf0), 32'd0);
    check("ena0_busy", 32'(busy), 32'd0);
    ena = 1'b1;

    // Reset 60 cycles into a write aborts it silently.
    @(negedge clk);
    wr_rdn = 1'b1; addr = 7'h05; wdata = 8'hC3; mode = 2'd0; start = 1'b1;
    cur_cpha = 1'b0; d0 = done_cnt; s = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (59) @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    exp_rdata = 8'h00;
    check("abort_cs_n", 32'(cs_n), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_spi_clk", 32'(spi_clk), 32'd0);
    check("abort_rdata", 32'(rdata), 32'd0);
    check("abort_lat", 32'(cyc - s), 32'd61);
    repeat (150) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_frame(1'b0, 7'h05, 8'h00, 2'd2, 1'b0);
    run_frame(1'b1, 7'h05, 8'h96, 2'd3, 1'b0);
    run_frame(1'b0, 7'h05, 8'h00, 2'd0, 1'b0);

    // CLK_DIV=1 instance latency.
    t_cs = -1; t_done = -1; t_busy = -1;
    @(negedge clk);
    start1 = 1'b1; s = cyc;
    for (int k = 1; k < 300 && t_busy < 0; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      off = cyc - s;
      if (!cs1_n && t_cs < 0) t_cs = off;
      if (done1 && t_done < 0) t_done = off;
      if (!busy1 && t_busy < 0) t_busy = off;
    end
    check("div1_cs_lat", 32'(t_cs), 32'd1);
    check("div1_done_lat", 32'(t_done), 32'(LAT1_DONE));
    check("div1_busy_lat", 32'(t_busy), 32'(LAT1_DONE + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
